hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Parametrised HI/LO execution unit for the EX stage of the MIPS pipeline.
- Owns the HI and LO registers and decodes R-type funct for mfhi/mthi/mflo/mtlo.
- Runs iterative signed/unsigned multiply and divide over multiple cycles.
- Exports Busy to the hazard unit, which stalls HI/LO consumers.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be ≥4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous, active-low reset
Start  in  1  funct/operands valid this cycle
Funct  in  6  R-type funct field
A  in  WIDTH  rs operand (multiplicand / dividend / mthi/mtlo source)
B  in  WIDTH  rt operand (multiplier / divisor)
Busy  out  1  operation in progress; new Start ignored
Done  out  1  one-cycle pulse, cycle after HI/LO written by mult/div
DivByZero  out  1  one-cycle pulse with Done when div/divu had B==0
Hi  out  WIDTH  current HI register
Lo  out  WIDTH  current LO register
MfData  out  WIDTH  combinational: Hi when Funct==010000, Lo when Funct==010010, else 0

Behaviour:
- Reset (async, Rst_n=0):
  - HI=LO=0, state IDLE.
  - Busy=Done=DivByZero=0; counter and datapath cleared.
  - Any in-flight operation is abandoned with no HI/LO write.
- Funct decode, acted on only when Start=1 and state IDLE:
  - 010001 mthi: HI<=A at that edge.
  - 010011 mtlo: LO<=A at that edge.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu: launch an operation.
  - 010000 mfhi, 010010 mflo, and all others: no state change. mfhi/mflo read via MfData only.
- States: IDLE, COMPUTE, FINISH.
  - IDLE -> COMPUTE on an accepted mult/multu/div/divu with B!=0 (or any mult).
  - COMPUTE: WIDTH cycles, counter counts WIDTH-1 down to 0.
  - COMPUTE -> FINISH when counter==0.
  - FINISH -> IDLE after 1 cycle.
- Accept edge t0:
  - Signed ops latch |A| and |B| plus result sign flags.
  - Unsigned ops latch the raw values.
- Multiply: shift-add, one multiplier bit per COMPUTE cycle, 2*WIDTH-bit product.
- Divide: restoring, one quotient bit per COMPUTE cycle.
- FINISH applies sign correction, then writes HI/LO at the edge leaving FINISH (t0+WIDTH+1):
  - mult: {HI,LO} = two's-complement product.
  - div: LO = quotient truncated toward zero; HI = remainder, sign follows dividend.
- Divide by zero (div/divu, B==0):
  - IDLE -> FINISH directly, no COMPUTE.
  - HI/LO unchanged; DivByZero=1 together with Done.
- Timing:
  - Busy=1 in every COMPUTE/FINISH cycle: WIDTH+1 cycles normally, 1 cycle for divide-by-zero.
  - Busy deasserts in the same cycle Done=1.
  - Done is registered, high for exactly one cycle after the HI/LO write.
  - A new Start is accepted in the Done cycle.
- Start while Busy: ignored entirely, including mthi/mtlo; no queuing.
- mfhi/mflo while Busy: MfData returns the old value. Stalling is the hazard unit's job.
- Hi/Lo outputs are registered and change only at write edges.

Test Plan:
1. WIDTH=32, Start mult, A=0xFFFFFFFD (-3), B=7 -> Busy high 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulses once.
2. multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. Same operands with mult -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
3. Divide cases:
   - div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu A=7, B=2 -> LO=3, HI=1.
   - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Preload HI=0x11, LO=0x22 via mthi/mtlo, then div A=5, B=0 -> Busy 1 cycle; Done=DivByZero=1 for one cycle; HI=0x11, LO=0x22.
5. mthi A=0x1234; next cycle Funct=010000 -> MfData=0x1234. During a mult, Start mtlo A=0x55 -> ignored; LO takes the product at completion.
6. Reset and back-to-back:
   - Rst_n low at cycle 10 of a mult -> Busy=0, HI=LO=0 immediately; no Done after release.
   - Start in the Done cycle -> accepted; second result correct.

Source files
------------

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the HI/LO unit.
// The master drives funct/operands; the slave returns status and HI/LO views.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic [WIDTH-1:0] MfData;

    modport master (
        output Start, Funct, A, B,
        input  Busy, Done, DivByZero, Hi, Lo, MfData
    );

    modport slave (
        input  Start, Funct, A, B,
        output Busy, Done, DivByZero, Hi, Lo, MfData
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO execution unit: mthi/mtlo/mfhi/mflo plus iterative shift-add multiply
// and restoring divide, one bit per cycle on magnitudes with a final sign fix.
module hilo_muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    hilo_muldiv_unit_if.slave  bus
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // mult: product high half; div: remainder
    logic [WIDTH-1:0]   sh_q, sh_d;       // mult: multiplier/low half; div: dividend/quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // mult: |multiplicand|; div: |divisor|
    logic               isdiv_q, isdiv_d;
    logic               qneg_q, qneg_d;   // product / quotient must be negated
    logic               rneg_q, rneg_d;   // remainder takes the dividend's sign
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     msum, dshift, ddiff;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        sgn      = ~bus.Funct[0];
        a_abs    = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        b_abs    = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        msum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        dshift   = {acc_q, sh_q[WIDTH-1]};
        ddiff    = dshift - {1'b0, opnd_q};
        prod     = {acc_q, sh_q};
        prod_fix = qneg_q ? -prod : prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opnd_d  = opnd_q;
        isdiv_d = isdiv_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    unique case (bus.Funct)
                        F_MTHI: hi_d = bus.A;
                        F_MTLO: lo_d = bus.A;
                        F_MULT, F_MULTU: begin
                            isdiv_d = 1'b0;
                            dbz_d   = 1'b0;
                            acc_d   = '0;
                            sh_d    = b_abs;
                            opnd_d  = a_abs;
                            qneg_d  = sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            rneg_d  = 1'b0;
                            cnt_d   = CNT_W'(WIDTH - 1);
                            state_d = COMPUTE;
                        end
                        F_DIV, F_DIVU: begin
                            isdiv_d = 1'b1;
                            qneg_d  = sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            rneg_d  = sgn & bus.A[WIDTH-1];
                            if (bus.B == '0) begin
                                dbz_d   = 1'b1;
                                state_d = FINISH;
                            end else begin
                                dbz_d   = 1'b0;
                                acc_d   = '0;
                                sh_d    = a_abs;
                                opnd_d  = b_abs;
                                cnt_d   = CNT_W'(WIDTH - 1);
                                state_d = COMPUTE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            COMPUTE: begin
                if (isdiv_q) begin
                    if (!ddiff[WIDTH]) begin
                        acc_d = ddiff[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = dshift[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = msum[WIDTH:1];
                    sh_d  = {msum[0], sh_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!dbz_q) begin
                    if (isdiv_q) begin
                        lo_d = qneg_q ? -sh_q : sh_q;
                        hi_d = rneg_q ? -acc_q : acc_q;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opnd_q  <= '0;
            isdiv_q <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opnd_q  <= opnd_d;
            isdiv_q <= isdiv_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = done_q;
    assign bus.DivByZero = done_q & dbz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
    assign bus.MfData    = (bus.Funct == F_MFHI) ? hi_q :
                           (bus.Funct == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: mult/div results, divide-by-zero,
// mfhi/mflo/mthi/mtlo, Start-while-Busy, mid-operation reset, back-to-back.
module tb_hilo_muldiv_unit;
    localparam int WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic Clk = 1'b0;
    logic Rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present the request for one clock, return at the next negedge.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Funct = f;
        bus.A     = a;
        bus.B     = b;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    // Counts remaining Busy cycles (bounded) and stops in the Done cycle.
    task automatic wait_done(input string tag, input int exp_busy, input logic exp_dbz);
        int n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge Clk);
        end
        chk({tag, " busy cycles"}, 64'(n), 64'(exp_busy));
        chk({tag, " done"}, 64'(bus.Done), 64'd1);
        chk({tag, " divbyzero"}, 64'(bus.DivByZero), 64'(exp_dbz));
    endtask

    task automatic op_check(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input int exp_busy, input logic exp_dbz);
        start_op(f, a, b);
        wait_done(tag, exp_busy, exp_dbz);
        @(negedge Clk);
        chk({tag, " done pulse ends"}, 64'(bus.Done), 64'd0);
        chk({tag, " hi"}, 64'(bus.Hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus.Lo), 64'(exp_lo));
    endtask

    initial begin
        int dones;
        bus.Start = 1'b0;
        bus.Funct = 6'd0;
        bus.A     = '0;
        bus.B     = '0;
        Rst_n     = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset busy", 64'(bus.Busy), 64'd0);
        chk("reset done", 64'(bus.Done), 64'd0);
        chk("reset dbz", 64'(bus.DivByZero), 64'd0);
        chk("reset hi", 64'(bus.Hi), 64'd0);
        chk("reset lo", 64'(bus.Lo), 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        op_check("mult -3*7", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
        op_check("multu ffffffff*2", F_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 33, 1'b0);
        op_check("mult -1*2", F_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
        op_check("mult 0x80000000*-1", F_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
        op_check("div -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
        op_check("divu 7/2", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33, 1'b0);
        op_check("div min/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1'b0);
        op_check("div 7/-2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0);
        op_check("divu big", F_DIVU, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 33, 1'b0);

        // Preload via mthi/mtlo, then divide by zero leaves them untouched.
        start_op(F_MTHI, 32'h11, 32'd0);
        start_op(F_MTLO, 32'h22, 32'd0);
        chk("mthi preload", 64'(bus.Hi), 64'h11);
        chk("mtlo preload", 64'(bus.Lo), 64'h22);
        op_check("div by zero", F_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1'b1);

        // mfhi/mflo read path.
        start_op(F_MTHI, 32'h1234, 32'd0);
        bus.Funct = F_MFHI;
        #1 chk("mfhi data", 64'(bus.MfData), 64'h1234);
        bus.Funct = F_MFLO;
        #1 chk("mflo data", 64'(bus.MfData), 64'h22);
        bus.Funct = 6'b100000;
        #1 chk("mf other funct", 64'(bus.MfData), 64'h0);
        @(negedge Clk);

        // mtlo during a mult is dropped; mflo still shows the old LO.
        start_op(F_MULT, 32'd3, 32'd5);
        repeat (3) @(negedge Clk);
        start_op(F_MTLO, 32'h55, 32'd0);
        chk("mtlo while busy", 64'(bus.Lo), 64'h22);
        bus.Funct = F_MFLO;
        #1 chk("mflo while busy", 64'(bus.MfData), 64'h22);
        wait_done("mult with mtlo", 29, 1'b0);
        @(negedge Clk);
        chk("mult with mtlo hi", 64'(bus.Hi), 64'h0);
        chk("mult with mtlo lo", 64'(bus.Lo), 64'd15);

        // Reset in the middle of a mult.
        start_op(F_MULT, 32'd7, 32'd9);
        repeat (8) @(negedge Clk);
        chk("busy before reset", 64'(bus.Busy), 64'd1);
        Rst_n = 1'b0;
        #1;
        chk("reset mid-op busy", 64'(bus.Busy), 64'd0);
        chk("reset mid-op hi", 64'(bus.Hi), 64'd0);
        chk("reset mid-op lo", 64'(bus.Lo), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Done === 1'b1) dones++;
        end
        chk("no done after reset", 64'(dones), 64'd0);
        chk("hi after reset", 64'(bus.Hi), 64'd0);

        // Back-to-back: second op launched in the Done cycle of the first.
        start_op(F_MULT, 32'd6, 32'd7);
        wait_done("b2b first", 33, 1'b0);
        chk("b2b first lo", 64'(bus.Lo), 64'd42);
        start_op(F_DIVU, 32'd100, 32'd7);
        wait_done("b2b second", 33, 1'b0);
        @(negedge Clk);
        chk("b2b second hi", 64'(bus.Hi), 64'd2);
        chk("b2b second lo", 64'(bus.Lo), 64'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
